// File: rtl/alu_batch_sequencer_pkg.sv
// Shared widths, state encoding and the terminating opcode for the ALU batch sequencer.
package alu_batch_sequencer_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] HALT_OP = 5'h1f;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_OP,
        LOAD,
        WAIT_SRC,
        EXEC,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/alu_batch_sequencer_if.sv
// BRAM port A/B and ALU connections seen by the batch sequencer.
interface alu_batch_sequencer_if;

    logic [alu_batch_sequencer_pkg::ADDR_W-1:0] addra;
    logic [alu_batch_sequencer_pkg::ADDR_W-1:0] addrb;
    logic [alu_batch_sequencer_pkg::DATA_W-1:0] dina;
    logic                                       wea;
    logic [alu_batch_sequencer_pkg::DATA_W-1:0] douta;
    logic [alu_batch_sequencer_pkg::DATA_W-1:0] doutb;
    logic [alu_batch_sequencer_pkg::OP_W-1:0]   op;
    logic [alu_batch_sequencer_pkg::DATA_W-1:0] alu_a;
    logic [alu_batch_sequencer_pkg::DATA_W-1:0] alu_b;
    logic [alu_batch_sequencer_pkg::DATA_W-1:0] alu_result;

    modport master (
        output addra, addrb, dina, wea, op, alu_a, alu_b,
        input  douta, doutb, alu_result
    );

    modport slave (
        input  addra, addrb, dina, wea, op, alu_a, alu_b,
        output douta, doutb, alu_result
    );

endinterface

// File: rtl/alu_batch_sequencer.sv
// Walks the op and operand tables in BRAM, feeds each pair through the ALU and
// stores the result, until the HALT opcode or the step limit.
module alu_batch_sequencer #(
    parameter logic [7:0] OP_BASE  = 8'd100,
    parameter logic [7:0] SRC_BASE = 8'd0,
    parameter logic [7:0] DST_BASE = 8'd200,
    parameter logic [7:0] MAX_OPS  = 8'd50,
    parameter int         RAM_LAT  = 1,
    parameter logic [4:0] HALT_OP  = alu_batch_sequencer_pkg::HALT_OP
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    alu_batch_sequencer_if.master                      bus,
    output logic                                       busy,
    output logic                                       done,
    output logic [alu_batch_sequencer_pkg::ADDR_W-1:0] op_count
);
    import alu_batch_sequencer_pkg::*;

    localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

    state_t              state_reg, state_next;
    logic [1:0]          wait_reg, wait_next;
    logic [ADDR_W-1:0]   op_ptr_reg, op_ptr_next;
    logic [ADDR_W-1:0]   src_ptr_reg, src_ptr_next;
    logic [ADDR_W-1:0]   dst_ptr_reg, dst_ptr_next;
    logic [ADDR_W-1:0]   addra_reg, addra_next;
    logic [ADDR_W-1:0]   addrb_reg, addrb_next;
    logic [DATA_W-1:0]   dina_reg, dina_next;
    logic                wea_reg, wea_next;
    logic [OP_W-1:0]     op_reg, op_next;
    logic [DATA_W-1:0]   alu_a_reg, alu_a_next;
    logic [DATA_W-1:0]   alu_b_reg, alu_b_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic [ADDR_W-1:0]   count_reg, count_next;
    logic [ADDR_W-1:0]   count_inc;

    assign count_inc = count_reg + ADDR_W'(1);

    // Outputs are registered on entry to a state, so each RAM address is
    // already on the bus during the state that issues it.
    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        op_ptr_next  = op_ptr_reg;
        src_ptr_next = src_ptr_reg;
        dst_ptr_next = dst_ptr_reg;
        addra_next   = addra_reg;
        addrb_next   = addrb_reg;
        dina_next    = dina_reg;
        wea_next     = 1'b0;
        op_next      = op_reg;
        alu_a_next   = alu_a_reg;
        alu_b_next   = alu_b_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        count_next   = count_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = FETCH;
                    busy_next    = 1'b1;
                    count_next   = '0;
                    op_ptr_next  = OP_BASE;
                    src_ptr_next = SRC_BASE;
                    dst_ptr_next = DST_BASE;
                    addra_next   = OP_BASE;
                end
            end
            FETCH: begin
                state_next = WAIT_OP;
                wait_next  = LAT_LOAD;
            end
            WAIT_OP: begin
                if (wait_reg != 2'd0) begin
                    wait_next = wait_reg - 2'd1;
                end else begin
                    op_next = bus.douta[OP_W-1:0];
                    if (bus.douta[OP_W-1:0] == HALT_OP) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD;
                        addra_next = src_ptr_reg;
                        addrb_next = src_ptr_reg + ADDR_W'(1);
                    end
                end
            end
            LOAD: begin
                state_next = WAIT_SRC;
                wait_next  = LAT_LOAD;
            end
            WAIT_SRC: begin
                if (wait_reg != 2'd0) begin
                    wait_next = wait_reg - 2'd1;
                end else begin
                    alu_a_next = bus.douta;
                    alu_b_next = bus.doutb;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // ALU has had a full cycle on the registered operands.
                state_next = WRITE;
                addra_next = dst_ptr_reg;
                dina_next  = bus.alu_result;
                wea_next   = 1'b1;
            end
            WRITE: begin
                op_ptr_next  = op_ptr_reg + ADDR_W'(1);
                src_ptr_next = src_ptr_reg + ADDR_W'(2);
                dst_ptr_next = dst_ptr_reg + ADDR_W'(1);
                count_next   = count_inc;
                if (MAX_OPS != '0 && count_inc == MAX_OPS) begin
                    state_next = DONE;
                end else begin
                    state_next = FETCH;
                    addra_next = op_ptr_reg + ADDR_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b1;
                busy_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            wait_reg    <= 2'd0;
            op_ptr_reg  <= OP_BASE;
            src_ptr_reg <= SRC_BASE;
            dst_ptr_reg <= DST_BASE;
            addra_reg   <= '0;
            addrb_reg   <= '0;
            dina_reg    <= '0;
            wea_reg     <= 1'b0;
            op_reg      <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            wait_reg    <= wait_next;
            op_ptr_reg  <= op_ptr_next;
            src_ptr_reg <= src_ptr_next;
            dst_ptr_reg <= dst_ptr_next;
            addra_reg   <= addra_next;
            addrb_reg   <= addrb_next;
            dina_reg    <= dina_next;
            wea_reg     <= wea_next;
            op_reg      <= op_next;
            alu_a_reg   <= alu_a_next;
            alu_b_reg   <= alu_b_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            count_reg   <= count_next;
        end
    end

    assign bus.addra = addra_reg;
    assign bus.addrb = addrb_reg;
    assign bus.dina  = dina_reg;
    assign bus.wea   = wea_reg;
    assign bus.op    = op_reg;
    assign bus.alu_a = alu_a_reg;
    assign bus.alu_b = alu_b_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign op_count  = count_reg;

endmodule

// File: tb/tb_alu_batch_sequencer.sv
// Three sequencer instances (lat 1, MAX_OPS=3, lat 2) each with a BRAM model and ALU,
// checked by directed vectors, hand-written corner sequences and random batches.
module tb_alu_batch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst_s   [3];
    logic        start_s [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic [7:0]  cnt_s   [3];
    logic [7:0]  addra_w [3];
    logic [7:0]  addrb_w [3];
    logic [15:0] dina_w  [3];
    logic        wea_w   [3];
    logic [4:0]  op_w    [3];
    logic [15:0] alu_a_w [3];
    logic [15:0] alu_b_w [3];

    logic [15:0] mem [3][256];
    logic [15:0] img [3][256];
    logic        load_req [3];
    logic [15:0] pa [3][3];
    logic [15:0] pb [3][3];

    logic [7:0]  wr_addr [3][1024];
    logic [15:0] wr_data [3][1024];
    int          wr_cyc  [3][1024];
    int          wr_n    [3] = '{0, 0, 0};

    function automatic logic [15:0] alu_f(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b);
        case (opc)
            5'd0:    alu_f = a + b;
            5'd1:    alu_f = a - b;
            5'd2:    alu_f = a & b;
            5'd3:    alu_f = a | b;
            5'd4:    alu_f = a ^ b;
            5'd5:    alu_f = a << b[3:0];
            default: alu_f = a + b + {11'd0, opc};
        endcase
    endfunction

    function automatic int lat_of(input int i);
        lat_of = (i == 2) ? 2 : 1;
    endfunction

    function automatic int max_of(input int i);
        max_of = (i == 1) ? 3 : 50;
    endfunction

    // BRAM model: synchronous read with a 1..3 stage output pipeline, port A write.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (load_req[i]) begin
                for (int a = 0; a < 256; a++) mem[i][a] <= img[i][a];
            end else if (wea_w[i]) begin
                mem[i][addra_w[i]] <= dina_w[i];
            end
            pa[i][0] <= mem[i][addra_w[i]];
            pb[i][0] <= mem[i][addrb_w[i]];
            pa[i][1] <= pa[i][0];
            pb[i][1] <= pb[i][0];
            pa[i][2] <= pa[i][1];
            pb[i][2] <= pb[i][1];
            if (wea_w[i]) begin
                if (wr_n[i] < 1024) begin
                    wr_addr[i][wr_n[i]] <= addra_w[i];
                    wr_data[i][wr_n[i]] <= dina_w[i];
                    wr_cyc[i][wr_n[i]]  <= cyc;
                end
                wr_n[i] <= wr_n[i] + 1;
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int         LAT  = (gi == 2) ? 2 : 1;
        localparam logic [7:0] MAXO = (gi == 1) ? 8'd3 : 8'd50;

        alu_batch_sequencer_if bus();

        assign bus.douta      = pa[gi][LAT-1];
        assign bus.doutb      = pb[gi][LAT-1];
        assign bus.alu_result = alu_f(bus.op, bus.alu_a, bus.alu_b);
        assign addra_w[gi]    = bus.addra;
        assign addrb_w[gi]    = bus.addrb;
        assign dina_w[gi]     = bus.dina;
        assign wea_w[gi]      = bus.wea;
        assign op_w[gi]       = bus.op;
        assign alu_a_w[gi]    = bus.alu_a;
        assign alu_b_w[gi]    = bus.alu_b;

        alu_batch_sequencer #(
            .MAX_OPS (MAXO),
            .RAM_LAT (LAT)
        ) dut (
            .clk      (clk),
            .rst      (rst_s[gi]),
            .start    (start_s[gi]),
            .bus      (bus),
            .busy     (busy_s[gi]),
            .done     (done_s[gi]),
            .op_count (cnt_s[gi])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed vectors: opcodes 0..3 (rest of the first 10 are ADD), operand words 0..7.
    typedef struct {
        int               inst;
        logic [3:0][4:0]  ops;
        logic [7:0][15:0] src;
        int               exp_count;
        logic [2:0][15:0] exp_res;
        int               exp_edges;
        int               exp_space;
    } vec_t;

    vec_t vecs [4];

    // Results of the last batch as observed on the DUT.
    int act_edges, act_w0, act_nw, busy_bad;

    // Reference model outputs.
    int          m_n, m_edges;
    bit          m_halted;
    logic [4:0]  m_last_op;
    logic [15:0] m_last_a, m_last_b;
    logic [15:0] m_data [64];

    task automatic load_img(input int i);
        load_req[i] = 1'b1;
        @(negedge clk);
        load_req[i] = 1'b0;
    endtask

    task automatic fill_vec(input int v);
        int i;
        i = vecs[v].inst;
        for (int a = 0; a < 256; a++) img[i][a] = 16'd0;
        for (int k = 0; k < 10; k++) img[i][100 + k] = (k < 4) ? {11'd0, vecs[v].ops[k]} : 16'd0;
        for (int k = 0; k < 8; k++) img[i][k] = vecs[v].src[k];
    endtask

    task automatic fill_random(input int i);
        int p;
        logic [31:0] r;
        for (int a = 0; a < 256; a++) img[i][a] = 16'($urandom);
        for (int k = 0; k < 50; k++) begin
            r = $urandom;
            img[i][100 + k] = {r[15:5], 5'($urandom_range(0, 30))};
        end
        p = $urandom_range(0, 63);
        if (p < 50) begin
            r = $urandom;
            img[i][100 + p] = {r[10:0], 5'h1f};
        end
    endtask

    // Step-by-step reading of the tables as the batch semantics define them.
    task automatic model_run(input int i);
        int lat, mx;
        logic [4:0]  opc;
        logic [15:0] a, b;
        lat = lat_of(i);
        mx  = max_of(i);
        m_n = 0;
        m_halted = 1'b0;
        for (int k = 0; k < 256; k++) begin
            opc = img[i][(100 + k) % 256][4:0];
            m_last_op = opc;
            if (opc == 5'h1f) begin
                m_halted = 1'b1;
                break;
            end
            a = img[i][(2 * k) % 256];
            b = img[i][(2 * k + 1) % 256];
            m_data[m_n] = alu_f(opc, a, b);
            m_n++;
            m_last_a = a;
            m_last_b = b;
            if (mx != 0 && m_n == mx) break;
        end
        m_edges = 2 + m_n * (4 + 2 * lat) + (m_halted ? 1 + lat : 0);
    endtask

    // Pulses start at the current point (just after a negedge) and waits for done.
    // extra >= 0 re-asserts start so that it is sampled at edge extra+1.
    task automatic do_batch(input int i, input int extra);
        act_w0 = wr_n[i];
        busy_bad = 0;
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        act_edges = 1;
        chk("count_clear_on_accept", 32'(cnt_s[i]), 32'd0);
        while (!done_s[i] && act_edges < 3000) begin
            if (!busy_s[i]) busy_bad++;
            start_s[i] = (act_edges == extra);
            @(negedge clk);
            act_edges++;
        end
        start_s[i] = 1'b0;
        act_nw = wr_n[i] - act_w0;
        chk("done_seen", 32'(done_s[i]), 32'd1);
        chk("busy_low_with_done", 32'(busy_s[i]), 32'd0);
        chk("busy_high_during", 32'(busy_bad), 32'd0);
        $display("batch inst=%0d writes=%0d op_count=%0d cycles=%0d", i, act_nw, cnt_s[i], act_edges);
    endtask

    task automatic check_model(input int i);
        int idx;
        model_run(i);
        chk("model_op_count", 32'(cnt_s[i]), 32'(m_n));
        chk("model_done_cycles", 32'(act_edges), 32'(m_edges));
        chk("model_write_count", 32'(act_nw), 32'(m_n));
        for (int k = 0; k < m_n && k < act_nw; k++) begin
            idx = act_w0 + k;
            if (idx < 1024) begin
                chk("model_write_addr", 32'(wr_addr[i][idx]), 32'(200 + k));
                chk("model_write_data", 32'(wr_data[i][idx]), 32'(m_data[k]));
                if (k > 0) chk("model_write_spacing", 32'(wr_cyc[i][idx] - wr_cyc[i][idx - 1]), 32'(4 + 2 * lat_of(i)));
            end
        end
        chk("model_op_hold", 32'(op_w[i]), 32'(m_last_op));
        if (m_n > 0) begin
            chk("model_alu_a_hold", 32'(alu_a_w[i]), 32'(m_last_a));
            chk("model_alu_b_hold", 32'(alu_b_w[i]), 32'(m_last_b));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0].inst = 0; vecs[0].ops = {5'd0, 5'd31, 5'd1, 5'd0};
        vecs[0].src = {16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd9, 16'd3, 16'd5};
        vecs[0].exp_count = 2; vecs[0].exp_res = {16'd0, 16'd5, 16'd8};
        vecs[0].exp_edges = 16; vecs[0].exp_space = 6;

        vecs[1].inst = 0; vecs[1].ops = {5'd0, 5'd0, 5'd0, 5'd31};
        vecs[1].src = {16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd9, 16'd3, 16'd5};
        vecs[1].exp_count = 0; vecs[1].exp_res = {16'd0, 16'd0, 16'd0};
        vecs[1].exp_edges = 4; vecs[1].exp_space = 6;

        vecs[2].inst = 1; vecs[2].ops = {5'd1, 5'd3, 5'd2, 5'd4};
        vecs[2].src = {16'h0002, 16'h0001, 16'h000F, 16'h00F0, 16'h00FF, 16'h1234, 16'h0FF0, 16'h00F0};
        vecs[2].exp_count = 3; vecs[2].exp_res = {16'h00FF, 16'h0034, 16'h0F00};
        vecs[2].exp_edges = 20; vecs[2].exp_space = 6;

        vecs[3].inst = 2; vecs[3].ops = {5'd0, 5'd31, 5'd1, 5'd0};
        vecs[3].src = {16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd9, 16'd3, 16'd5};
        vecs[3].exp_count = 2; vecs[3].exp_res = {16'd0, 16'd5, 16'd8};
        vecs[3].exp_edges = 21; vecs[3].exp_space = 8;

        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1;
            start_s[i] = 1'b0;
            load_req[i] = 1'b0;
            for (int a = 0; a < 256; a++) img[i][a] = 16'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_addra", 32'(addra_w[i]), 32'd0);
            chk("reset_wea", 32'(wea_w[i]), 32'd0);
            chk("reset_busy", 32'(busy_s[i]), 32'd0);
            chk("reset_done", 32'(done_s[i]), 32'd0);
            chk("reset_op_count", 32'(cnt_s[i]), 32'd0);
            chk("reset_op", 32'(op_w[i]), 32'd0);
            chk("reset_alu_a", 32'(alu_a_w[i]), 32'd0);
            rst_s[i] = 1'b0;
        end
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 4; v++) begin
            int i;
            i = vecs[v].inst;
            fill_vec(v);
            load_img(i);
            do_batch(i, -1);
            chk("vec_op_count", 32'(cnt_s[i]), 32'(vecs[v].exp_count));
            chk("vec_done_cycles", 32'(act_edges), 32'(vecs[v].exp_edges));
            chk("vec_write_count", 32'(act_nw), 32'(vecs[v].exp_count));
            for (int k = 0; k < vecs[v].exp_count && k < act_nw; k++) begin
                chk("vec_write_addr", 32'(wr_addr[i][act_w0 + k]), 32'(200 + k));
                chk("vec_write_data", 32'(wr_data[i][act_w0 + k]), 32'(vecs[v].exp_res[k]));
                if (k > 0) chk("vec_write_spacing", 32'(wr_cyc[i][act_w0 + k] - wr_cyc[i][act_w0 + k - 1]), 32'(vecs[v].exp_space));
            end
            check_model(i);
            @(negedge clk);
            chk("vec_done_one_cycle", 32'(done_s[i]), 32'd0);
            chk("vec_idle_busy", 32'(busy_s[i]), 32'd0);
        end

        // start re-pulsed mid-batch, then during the DONE state.
        fill_vec(0);
        load_img(0);
        do_batch(0, 5);
        check_model(0);
        model_run(0);
        do_batch(0, m_edges - 1);
        check_model(0);
        repeat (3) @(negedge clk);
        chk("start_in_done_ignored_busy", 32'(busy_s[0]), 32'd0);
        chk("start_in_done_ignored_writes", 32'(wr_n[0] - act_w0), 32'd2);

        // Reset during WAIT_SRC of step 2 aborts without a second write.
        act_w0 = wr_n[0];
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst_s[0] = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy_s[0]), 32'd0);
        chk("abort_wea", 32'(wea_w[0]), 32'd0);
        chk("abort_op_count", 32'(cnt_s[0]), 32'd0);
        rst_s[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_write_count", 32'(wr_n[0] - act_w0), 32'd1);
        chk("abort_stays_idle", 32'(busy_s[0]), 32'd0);
        do_batch(0, -1);
        check_model(0);

        // Back-to-back batches: second start in the done cycle.
        do_batch(0, -1);
        check_model(0);
        do_batch(0, -1);
        check_model(0);

        // Random batches on all three configurations.
        for (int it = 0; it < 9; it++) begin
            int i;
            i = it % 3;
            fill_random(i);
            load_img(i);
            do_batch(i, -1);
            check_model(i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
